pc_sequencer: RTL and testbench

- Parametrised next-generation program counter and sequencer for the CSE141L core.
- Produces the instruction line number each cycle and supports:
  - selectable per-program start addresses
  - relative and absolute conditional branches
  - unconditional call/return through a small hardware return-address stack
  - halt/done handshake to the testbench
- Sits between the decoder/ALU flag outputs and the instruction ROM address input.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/ret_stack.sv | 47 ++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Purpose : shared encodings for the program-counter sequencer (FSM states, next-PC select codes).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pc_seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    HALTED = ST_HALTED
  } state_t;

  // Source of the next program counter value.
  typedef enum logic [2:0] {
    HOLD,
    INC,
    REL,
    ABS,
    POP,
    LOAD
  } pc_sel_t;

  // Width of a program-select field; a single program still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Purpose : control/status bundle between decoder+ALU, the sequencer and the instruction ROM.
// Latency : n/a (wires only); status signals are registered inside the sequencer.
// Backpressure: none; control inputs are sampled every clock edge.
// Ports   : master drives Start/ProgSel/BranchEn/BranchAbs/ALU_flag/Call/Ret/Halt/Target and
//           observes ProgCtr/Running/Done/StackErr; slave is the sequencer side.
interface pc_sequencer_if #(
  parameter int PC_W      = 11,
  parameter int TGT_W     = 8,
  parameter int NUM_PROGS = 3
);
  import pc_seq_pkg::*;

  localparam int SEL_W = sel_width(NUM_PROGS);

  logic             Start;
  logic [SEL_W-1:0] ProgSel;
  logic             BranchEn;
  logic             BranchAbs;
  logic             ALU_flag;
  logic             Call;
  logic             Ret;
  logic             Halt;
  logic [TGT_W-1:0] Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             StackErr;

  modport master (
    output Start, ProgSel, BranchEn, BranchAbs, ALU_flag, Call, Ret, Halt, Target,
    input  ProgCtr, Running, Done, StackErr
  );

  modport slave (
    input  Start, ProgSel, BranchEn, BranchAbs, ALU_flag, Call, Ret, Halt, Target,
    output ProgCtr, Running, Done, StackErr
  );

endinterface

// File: rtl/ret_stack.sv
// Purpose : small LIFO of return addresses for call/return.
// Latency : push/pop take effect on the next edge; top/full/empty reflect the current contents.
// Backpressure: push while full and pop while empty are ignored (the caller flags the error).
// Ports   : Clk, Reset (sync, active-high), push, pop, clear, din -> top, full, empty.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int           AW    = $clog2(DEPTH);
  localparam logic [AW:0]  ONE   = (AW+1)'(1);
  localparam logic [AW:0]  LIMIT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_m1;
  logic [AW-1:0] top_idx;

  // Entry count is one wider than the index so full and empty are distinguishable.
  assign cnt_m1  = cnt - ONE;
  assign top_idx = cnt_m1[AW-1:0];
  assign top     = mem[top_idx];
  assign full    = (cnt == LIMIT);
  assign empty   = (cnt == '0);

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[cnt[AW-1:0]] <= din;
      cnt              <= cnt + ONE;
    end else if (pop && !empty) begin
      cnt <= cnt_m1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose : program counter / sequencer: program start select, branches, call/return, halt/done.
// Latency : one cycle; every output is registered and reflects the inputs sampled on the prior edge.
// Backpressure: none; a new control decision is taken every cycle.
// Ports   : Clk, Reset (sync, active-high), bus (pc_sequencer_if.slave) carrying the control
//           inputs and the ProgCtr/Running/Done/StackErr status outputs.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                          PC_W       = 11,
  parameter int                          TGT_W      = 8,
  parameter int                          NUM_PROGS  = 3,
  parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASES = {11'd512, 11'd256, 11'd0},
  parameter int                          RAS_DEPTH  = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  localparam int SEL_W = sel_width(NUM_PROGS);

  state_t          state, state_nxt;
  pc_sel_t         pc_sel;
  logic            push, pop, clear, err_set;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, pc_rel, pc_abs, pc_base, stk_top;
  logic            running_q, done_q, stk_err_q;

  // All arithmetic is PC_W wide so it wraps naturally.
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + {{(PC_W-TGT_W){bus.Target[TGT_W-1]}}, bus.Target};
  assign pc_abs = {{(PC_W-TGT_W){1'b0}}, bus.Target};

  // An out-of-range program index falls back to program 0.
  always_comb begin
    pc_base = PROG_BASES[PC_W-1:0];
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (bus.ProgSel == SEL_W'(i)) pc_base = PROG_BASES[i*PC_W +: PC_W];
    end
  end

  // Decision logic. Start wins over everything; in RUN the order is
  // Halt > Ret > Call > taken branch > increment. Push and pop are exclusive by construction.
  always_comb begin
    state_nxt = state;
    pc_sel    = HOLD;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    err_set   = 1'b0;
    if (bus.Start) begin
      state_nxt = IDLE;
      pc_sel    = LOAD;
      clear     = 1'b1;
    end else begin
      case (state)
        IDLE: state_nxt = RUN;
        RUN: begin
          if (bus.Halt) begin
            state_nxt = HALTED;
          end else if (bus.Ret) begin
            if (!stk_empty) begin
              pc_sel = POP;
              pop    = 1'b1;
            end else begin
              state_nxt = HALTED;
              err_set   = 1'b1;
            end
          end else if (bus.Call) begin
            if (!stk_full) begin
              pc_sel = REL;
              push   = 1'b1;
            end else begin
              state_nxt = HALTED;
              err_set   = 1'b1;
            end
          end else if (bus.BranchEn && bus.ALU_flag) begin
            pc_sel = bus.BranchAbs ? ABS : REL;
          end else begin
            pc_sel = INC;
          end
        end
        default: state_nxt = state;  // HALTED waits for Start or Reset
      endcase
    end
  end

  always_comb begin
    case (pc_sel)
      INC:     pc_nxt = pc_inc;
      REL:     pc_nxt = pc_rel;
      ABS:     pc_nxt = pc_abs;
      POP:     pc_nxt = stk_top;
      LOAD:    pc_nxt = pc_base;
      default: pc_nxt = pc_q;
    endcase
  end

  // FSM with registered status outputs derived from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pc_q      <= PROG_BASES[PC_W-1:0];
      running_q <= 1'b0;
      done_q    <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      running_q <= (state_nxt == RUN);
      done_q    <= (state_nxt == HALTED);
      if (clear)        stk_err_q <= 1'b0;
      else if (err_set) stk_err_q <= 1'b1;
    end
  end

  ret_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.ProgCtr  = pc_q;
  assign bus.Running  = running_q;
  assign bus.Done     = done_q;
  assign bus.StackErr = stk_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int PC_W      = 11;
  localparam int TGT_W     = 8;
  localparam int NUM_PROGS = 3;
  localparam int RAS_DEPTH = 4;
  localparam int MASK      = (1 << PC_W) - 1;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pc_sequencer_if #(.PC_W(PC_W), .TGT_W(TGT_W), .NUM_PROGS(NUM_PROGS)) bus ();

  pc_sequencer #(
    .PC_W       (PC_W),
    .TGT_W      (TGT_W),
    .NUM_PROGS  (NUM_PROGS),
    .PROG_BASES ({11'd512, 11'd256, 11'd0}),
    .RAS_DEPTH  (RAS_DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state 0=idle 1=run 2=halted, PC as an integer, stack as a queue.
  int bases [NUM_PROGS] = '{0, 256, 512};
  int m_st  = 0;
  int m_pc  = 0;
  int m_stk [$];
  bit m_err = 0;

  task automatic model_step();
    int off, sel;
    off = int'(bus.Target);
    if (off >= 128) off -= 256;
    sel = int'(bus.ProgSel);
    if (sel >= NUM_PROGS) sel = 0;
    if (Reset) begin
      m_st = 0; m_pc = bases[0]; m_stk.delete(); m_err = 0;
    end else if (bus.Start) begin
      m_st = 0; m_pc = bases[sel]; m_stk.delete(); m_err = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (bus.Halt) m_st = 2;
      else if (bus.Ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_st = 2; m_err = 1; end
      end else if (bus.Call) begin
        if (m_stk.size() < RAS_DEPTH) begin
          m_stk.push_back((m_pc + 1) & MASK);
          m_pc = (m_pc + off) & MASK;
        end else begin m_st = 2; m_err = 1; end
      end else if (bus.BranchEn && bus.ALU_flag) begin
        m_pc = bus.BranchAbs ? int'(bus.Target) : ((m_pc + off) & MASK);
      end else m_pc = (m_pc + 1) & MASK;
    end
  endtask

  // Advance one clock, updating the model from the inputs the DUT samples on this edge.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit st, input int sel, input bit br, input bit ab, input bit fl,
                       input bit cl, input bit rt, input bit hl, input int tgt);
    bus.Start = st; bus.ProgSel = 2'(sel); bus.BranchEn = br; bus.BranchAbs = ab;
    bus.ALU_flag = fl; bus.Call = cl; bus.Ret = rt; bus.Halt = hl; bus.Target = 8'(tgt);
  endtask

  function automatic logic [13:0] obs();
    return {bus.ProgCtr, bus.Running, bus.Done, bus.StackErr};
  endfunction

  function automatic logic [13:0] pk(input int pc, input bit r, input bit d, input bit e);
    return {11'(pc), r, d, e};
  endfunction

  function automatic logic [13:0] model_exp();
    return {11'(m_pc), m_st == 1, m_st == 2, m_err};
  endfunction

  task automatic test_reset();
    logic [13:0] e;
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); checks++; e = pk(0, 0, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL reset_state got %h exp %h", obs(), e); end
    end
    Reset = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); checks++; e = pk(256, 0, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL start_load got %h exp %h", obs(), e); end
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); checks++; e = pk(256 + i, 1, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL run_inc%0d got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_branch();
    logic [13:0] e;
    drive(0, 1, 1, 1, 1, 0, 0, 0, 20); tick();
    checks++; e = pk(20, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL br_abs20 got %h exp %h", obs(), e); end
    drive(0, 1, 1, 0, 1, 0, 0, 0, -5); tick();
    checks++; e = pk(15, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL br_rel_taken got %h exp %h", obs(), e); end
    drive(0, 1, 1, 1, 1, 0, 0, 0, 20); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0, -5); tick();
    checks++; e = pk(21, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL br_not_taken got %h exp %h", obs(), e); end
    drive(0, 1, 1, 1, 1, 0, 0, 0, 200); tick();
    checks++; e = pk(200, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL br_abs200 got %h exp %h", obs(), e); end
  endtask

  task automatic test_call_ret();
    logic [13:0] e;
    drive(0, 1, 1, 1, 1, 0, 0, 0, 10); tick();
    drive(0, 1, 0, 0, 0, 1, 0, 0, 30); tick();
    checks++; e = pk(40, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL call got %h exp %h", obs(), e); end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    checks++; e = pk(42, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL after_call got %h exp %h", obs(), e); end
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0); tick();
    checks++; e = pk(11, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL ret got %h exp %h", obs(), e); end
    tick();  // stack now empty: underflow halts with error
    checks++; e = pk(11, 0, 1, 1);
    if (obs() !== e) begin errors++; $display("FAIL ret_empty got %h exp %h", obs(), e); end
  endtask

  task automatic test_stack_overflow();
    logic [13:0] e;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    checks++; e = pk(0, 0, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL restart_clears got %h exp %h", obs(), e); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(); checks++; e = pk(i, 1, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL nest_call%0d got %h exp %h", i, obs(), e); end
    end
    tick();
    checks++; e = pk(4, 0, 1, 1);
    if (obs() !== e) begin errors++; $display("FAIL overflow got %h exp %h", obs(), e); end
    drive(0, 0, 1, 1, 1, 0, 0, 0, 99); tick();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL halted_hold got %h exp %h", obs(), e); end
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    checks++; e = pk(512, 0, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL start_after_err got %h exp %h", obs(), e); end
  endtask

  task automatic test_wrap_halt();
    logic [13:0] e;
    drive(0, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 2, 1, 1, 1, 0, 0, 0, 0); tick();
    drive(0, 2, 1, 0, 1, 0, 0, 0, -1); tick();
    checks++; e = pk(2047, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL wrap_neg got %h exp %h", obs(), e); end
    drive(0, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    checks++; e = pk(0, 1, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL wrap_inc got %h exp %h", obs(), e); end
    drive(0, 2, 1, 1, 1, 0, 0, 0, 3); tick();
    drive(0, 2, 1, 0, 1, 0, 0, 1, 50); tick();
    checks++; e = pk(3, 0, 1, 0);
    if (obs() !== e) begin errors++; $display("FAIL halt_prio got %h exp %h", obs(), e); end
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0); tick();
    checks++; e = pk(256, 0, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL start_halt got %h exp %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 1, 1, 0, 0, 0, 77); tick();
    drive(0, 1, 0, 0, 0, 1, 0, 0, 5); tick();  // push one entry before reset
    drive(0, 1, 1, 1, 1, 0, 0, 0, 77); tick();
    Reset = 1'b1; drive(0, 1, 0, 0, 0, 1, 0, 0, 9); tick();
    checks++; e = pk(0, 0, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL reset_mid_run got %h exp %h", obs(), e); end
    Reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();  // stack must be empty after reset
    checks++; e = pk(0, 0, 1, 1);
    if (obs() !== e) begin errors++; $display("FAIL reset_empties got %h exp %h", obs(), e); end
    Reset = 1'b1; tick();
    checks++; e = pk(0, 0, 0, 0);
    if (obs() !== e) begin errors++; $display("FAIL reset_mid_halt got %h exp %h", obs(), e); end
    Reset = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] e;
    Reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    Reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, NUM_PROGS - 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 255));
      tick();
      checks++; e = model_exp();
      if (obs() !== e) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs(), e);
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_branch();
    test_call_ret();
    test_stack_overflow();
    test_wrap_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
